// File: rtl/hazard_scoreboard_unit_if.sv
// Purpose: ID/EX/MEM/WB hazard-control bundle between the pipeline and
//          hazard_scoreboard_unit.
// Ports (slave view = the hazard unit):
//   in : id_valid, id_rs1/rs2, id_use_rs1/rs2, id_rd, id_reg_we, id_long,
//        ex_rd, ex_reg_we, mem_rd, mem_reg_we, wb_valid, wb_rd, redirect
//   out: stall, if_we, flush, fwd_a, fwd_b, busy_cnt
interface hazard_scoreboard_unit_if #(
    parameter int unsigned AW = 5
);
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [AW-1:0] id_rd;
    logic          id_reg_we;
    logic          id_long;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_we;
    logic [AW-1:0] mem_rd;
    logic          mem_reg_we;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          redirect;
    logic          stall;
    logic          if_we;
    logic          flush;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [3:0]    busy_cnt;

    // Pipeline side
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_we, id_long, ex_rd, ex_reg_we, mem_rd, mem_reg_we,
               wb_valid, wb_rd, redirect,
        input  stall, if_we, flush, fwd_a, fwd_b, busy_cnt
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_we, id_long, ex_rd, ex_reg_we, mem_rd, mem_reg_we,
               wb_valid, wb_rd, redirect,
        output stall, if_we, flush, fwd_a, fwd_b, busy_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Purpose: ID/EX hazard control: operand forwarding selects, a per-register
//          scoreboard plus in-flight counter for long (variable-latency) ops,
//          and a multi-cycle flush sequencer after a redirect.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - hazard_scoreboard_unit_if.slave (ID/EX/MEM/WB info in; stall,
//          if_we, flush, fwd_a/b, busy_cnt out)
module hazard_scoreboard_unit #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned MAX_OUT   = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_scoreboard_unit_if.slave  bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned FC_W  = 3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic {S_IDLE, S_FLUSH} state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

    logic              stall_c;
    logic              flush_c;
    logic [1:0]        fwd_a_c;
    logic [1:0]        fwd_b_c;
    logic              issue_c;
    logic              wb_eff_c;

    // Operand select, nearest producer wins
    function automatic logic [1:0] fwd_sel(input logic use_s, input logic [AW-1:0] s);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_s && s != '0) begin
            if (bus.ex_reg_we && bus.ex_rd == s)       sel = FWD_EX;
            else if (bus.mem_reg_we && bus.mem_rd == s) sel = FWD_MEM;
            else if (bus.wb_valid && bus.wb_rd == s)    sel = FWD_WB;
        end
        return sel;
    endfunction

    // A busy register is not a hazard when its long result lands this cycle
    function automatic logic busy_hit(input logic use_s, input logic [AW-1:0] s);
        return use_s && s != '0 && busy_q[s] && !(bus.wb_valid && bus.wb_rd == s);
    endfunction

    // Hazard detection, issue and next-state computation
    always_comb begin
        logic raw;
        logic waw;
        logic cap;
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;

        fwd_a_c = fwd_sel(bus.id_use_rs1, bus.id_rs1);
        fwd_b_c = fwd_sel(bus.id_use_rs2, bus.id_rs2);

        raw = busy_hit(bus.id_use_rs1, bus.id_rs1) || busy_hit(bus.id_use_rs2, bus.id_rs2);
        waw = busy_hit(bus.id_reg_we, bus.id_rd);
        cap = bus.id_long && busy_cnt_q == CNT_W'(MAX_OUT) && !bus.wb_valid;

        // Redirect and flushing both suppress stall
        stall_c = bus.id_valid && (raw || waw || cap) && state_q == S_IDLE && !bus.redirect;
        flush_c = bus.redirect || state_q == S_FLUSH;
        issue_c = bus.id_valid && !stall_c && state_q == S_IDLE && !bus.redirect;

        // A writeback with nothing in flight is dropped
        wb_eff_c = bus.wb_valid && busy_cnt_q != '0;

        // Clear before set so same-register issue+retire leaves the bit at 1
        if (wb_eff_c) busy_d[bus.wb_rd] = 1'b0;
        if (issue_c && bus.id_long && bus.id_rd != '0) busy_d[bus.id_rd] = 1'b1;
        busy_d[0] = 1'b0;

        busy_cnt_d = busy_cnt_q + CNT_W'(issue_c && bus.id_long) - CNT_W'(wb_eff_c);

        // Flush sequencer: FLUSH_CYC cycles counted from the last redirect
        if (bus.redirect) begin
            fcnt_d  = FC_W'(FLUSH_CYC - 1);
            state_d = (FLUSH_CYC > 1) ? S_FLUSH : S_IDLE;
        end else if (state_q == S_FLUSH) begin
            fcnt_d = fcnt_q - FC_W'(1);
            if (fcnt_q <= FC_W'(1)) state_d = S_IDLE;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fcnt_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Outputs held at reset values while rst is high
    assign bus.stall    = stall_c && !rst;
    assign bus.if_we    = !(stall_c && !rst);
    assign bus.flush    = flush_c && !rst;
    assign bus.fwd_a    = rst ? FWD_RF : fwd_a_c;
    assign bus.fwd_b    = rst ? FWD_RF : fwd_b_c;
    assign bus.busy_cnt = busy_cnt_q;

    // A long-op writeback must always have something in flight
    wb_has_owner: assert property (@(posedge clk) disable iff (rst)
        bus.wb_valid |-> busy_cnt_q != '0);
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Purpose: directed self-checking bench for hazard_scoreboard_unit.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_hazard_scoreboard_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_scoreboard_unit_if #(.AW(5)) bus ();

    hazard_scoreboard_unit #(
        .NREG(32), .AW(5), .MAX_OUT(4), .FLUSH_CYC(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus.id_valid   = 1'b0;
        bus.id_rs1     = '0;
        bus.id_rs2     = '0;
        bus.id_use_rs1 = 1'b0;
        bus.id_use_rs2 = 1'b0;
        bus.id_rd      = '0;
        bus.id_reg_we  = 1'b0;
        bus.id_long    = 1'b0;
        bus.ex_rd      = '0;
        bus.ex_reg_we  = 1'b0;
        bus.mem_rd     = '0;
        bus.mem_reg_we = 1'b0;
        bus.wb_valid   = 1'b0;
        bus.wb_rd      = '0;
        bus.redirect   = 1'b0;
    endtask

    task automatic id_op(input logic lng, input logic [4:0] rd, input logic we,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        bus.id_valid   = 1'b1;
        bus.id_long    = lng;
        bus.id_rd      = rd;
        bus.id_reg_we  = we;
        bus.id_rs1     = rs1;
        bus.id_use_rs1 = u1;
        bus.id_rs2     = rs2;
        bus.id_use_rs2 = u2;
    endtask

    task automatic wb(input logic [4:0] rd);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
    endtask

    // Advance to the next falling edge with inputs cleared
    task automatic next();
        @(negedge clk);
        quiet();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        quiet();
        rst = 1'b1;
        #12;
        chk("rst_stall", 8'(bus.stall), 8'd0);
        chk("rst_if_we", 8'(bus.if_we), 8'd1);
        chk("rst_flush", 8'(bus.flush), 8'd0);
        chk("rst_busy_cnt", 8'(bus.busy_cnt), 8'd0);
        chk("rst_fwd_a", 8'(bus.fwd_a), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Forwarding priority (short ops only)
        next();
        id_op(1'b0, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0);
        bus.ex_rd = 5'd5;  bus.ex_reg_we = 1'b1;
        bus.mem_rd = 5'd5; bus.mem_reg_we = 1'b1;
        bus.wb_rd = 5'd5;
        #1 chk("fwd_ex", 8'(bus.fwd_a), 8'd1);
        chk("fwd_b_unused", 8'(bus.fwd_b), 8'd0);
        bus.ex_reg_we = 1'b0;
        #1 chk("fwd_mem", 8'(bus.fwd_a), 8'd2);
        bus.mem_reg_we = 1'b0;
        #1 chk("fwd_none_no_wb", 8'(bus.fwd_a), 8'd0);
        bus.ex_reg_we = 1'b1; bus.id_rs1 = 5'd0; bus.ex_rd = 5'd0;
        #1 chk("fwd_x0", 8'(bus.fwd_a), 8'd0);

        // Long RAW on x7
        next();
        id_op(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1 chk("long7_issue_stall", 8'(bus.stall), 8'd0);
        next();
        chk("long7_cnt", 8'(bus.busy_cnt), 8'd1);
        id_op(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1 chk("waw7_stall", 8'(bus.stall), 8'd1);
        next();
        id_op(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        #1 chk("raw7_stall", 8'(bus.stall), 8'd1);
        chk("raw7_if_we", 8'(bus.if_we), 8'd0);
        next();
        id_op(1'b0, 5'd8, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        wb(5'd7);
        #1 chk("raw7_wb_stall", 8'(bus.stall), 8'd0);
        chk("raw7_wb_if_we", 8'(bus.if_we), 8'd1);
        chk("raw7_wb_fwd_a", 8'(bus.fwd_a), 8'd3);
        next();
        chk("raw7_cnt_after", 8'(bus.busy_cnt), 8'd0);
        id_op(1'b0, 5'd8, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        #1 chk("x7_cleared", 8'(bus.stall), 8'd0);

        // Capacity: four long ops in flight
        for (int r = 1; r <= 4; r++) begin
            next();
            id_op(1'b1, 5'(r), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            #1 chk("cap_fill_stall", 8'(bus.stall), 8'd0);
        end
        next();
        chk("cap_cnt_full", 8'(bus.busy_cnt), 8'd4);
        id_op(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1 chk("cap_stall", 8'(bus.stall), 8'd1);
        next();
        id_op(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        wb(5'd1);
        #1 chk("cap_wb_issue", 8'(bus.stall), 8'd0);
        next();
        chk("cap_cnt_same", 8'(bus.busy_cnt), 8'd4);
        id_op(1'b0, 5'd11, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1);
        #1 chk("cap_x10_busy", 8'(bus.stall), 8'd1);
        bus.id_rs2 = 5'd0;
        #1 chk("cap_x1_free", 8'(bus.stall), 8'd0);
        next(); wb(5'd2);
        next(); wb(5'd3);
        next(); wb(5'd4);
        next(); wb(5'd10);
        next();
        chk("cap_drained", 8'(bus.busy_cnt), 8'd0);

        // Same-register issue and retire on x9
        id_op(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        next();
        id_op(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        wb(5'd9);
        #1 chk("coll_waw_pass", 8'(bus.stall), 8'd0);
        next();
        chk("coll_cnt", 8'(bus.busy_cnt), 8'd1);
        id_op(1'b0, 5'd11, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
        #1 chk("coll_x9_busy", 8'(bus.stall), 8'd1);
        wb(5'd9);
        #1 chk("coll_x9_wb", 8'(bus.stall), 8'd0);
        next();
        chk("coll_cnt_zero", 8'(bus.busy_cnt), 8'd0);

        // Flush sequencing with an outstanding hazard on x12
        id_op(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        next();
        id_op(1'b0, 5'd13, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0);
        bus.redirect = 1'b1;
        #1 chk("fl_t_flush", 8'(bus.flush), 8'd1);
        chk("fl_t_stall", 8'(bus.stall), 8'd0);
        next();
        id_op(1'b0, 5'd13, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0);
        #1 chk("fl_t1_flush", 8'(bus.flush), 8'd1);
        chk("fl_t1_stall", 8'(bus.stall), 8'd0);
        next();
        id_op(1'b0, 5'd13, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0);
        #1 chk("fl_t2_flush", 8'(bus.flush), 8'd0);
        chk("fl_t2_stall", 8'(bus.stall), 8'd1);
        next();
        bus.redirect = 1'b1;
        #1 chk("fl2_t_flush", 8'(bus.flush), 8'd1);
        next();
        bus.redirect = 1'b1;
        #1 chk("fl2_t1_flush", 8'(bus.flush), 8'd1);
        next();
        #1 chk("fl2_t2_flush", 8'(bus.flush), 8'd1);
        next();
        #1 chk("fl2_t3_flush", 8'(bus.flush), 8'd0);
        chk("fl_cnt_kept", 8'(bus.busy_cnt), 8'd1);
        wb(5'd12);
        next();
        chk("fl_cnt_zero", 8'(bus.busy_cnt), 8'd0);

        // Asynchronous reset in the middle of a flush with 3 ops in flight
        for (int r = 1; r <= 3; r++) begin
            id_op(1'b1, 5'(r), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            next();
        end
        chk("mid_cnt3", 8'(bus.busy_cnt), 8'd3);
        bus.redirect = 1'b1;
        @(posedge clk);
        #1 quiet();
        #1 chk("mid_flushing", 8'(bus.flush), 8'd1);
        rst = 1'b1;
        #1 chk("mid_rst_cnt", 8'(bus.busy_cnt), 8'd0);
        chk("mid_rst_flush", 8'(bus.flush), 8'd0);
        chk("mid_rst_stall", 8'(bus.stall), 8'd0);
        chk("mid_rst_if_we", 8'(bus.if_we), 8'd1);
        @(negedge clk);
        rst = 1'b0;
        id_op(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
        #1 chk("post_rst_stall", 8'(bus.stall), 8'd0);
        chk("post_rst_flush", 8'(bus.flush), 8'd0);
        next();
        chk("post_rst_cnt", 8'(bus.busy_cnt), 8'd1);
        wb(5'd1);
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the pipeline's combinational forwarding and hazard control.
- Adds a per-register scoreboard for variable-latency (long) operations such as loads waiting on a memory handshake or multi-cycle ALU ops, plus an outstanding-op counter.
- Adds a multi-cycle redirect flush FSM.
- Sits between ID and EX: produces issue stall, IF write-enable, flush, and rs1/rs2 forwarding selects.

Parameters:
- NREG, 32, architectural register count; register 0 is hardwired zero.
- AW, 5, register index width (log2 NREG).
- MAX_OUT, 4, maximum long ops in flight (1..15).
- FLUSH_CYC, 2, cycles flush stays asserted after a redirect (1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds an instruction.
- id_rs1  in  AW  source 1 index.
- id_rs2  in  AW  source 2 index.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  AW  destination index.
- id_reg_we  in  1  instruction writes rd.
- id_long  in  1  instruction completes through the long-op writeback port.
- ex_rd  in  AW  EX-stage destination.
- ex_reg_we  in  1  EX writes rd (short ops only).
- mem_rd  in  AW  MEM-stage destination.
- mem_reg_we  in  1  MEM writes rd (short ops only).
- wb_valid  in  1  long-op result written this cycle.
- wb_rd  in  AW  long-op destination.
- redirect  in  1  taken branch/jump resolved in EX.
- stall  out  1  hold ID, insert bubble into EX.
- if_we  out  1  PC/IF-ID write enable; equals ~stall.
- flush  out  1  kill IF/ID contents.
- fwd_a  out  2  rs1 operand select: 00 regfile, 01 EX, 10 MEM, 11 WB.
- fwd_b  out  2  rs2 operand select, same encoding.
- busy_cnt  out  4  long ops in flight.

Behaviour:
- Reset (asynchronous, immediate): busy bits all 0; busy_cnt=0; FSM=IDLE; flush=0; stall=0; if_we=1; fwd_a=fwd_b=00.
- Forwarding (combinational) for each used source s with s!=0:
  - EX match (ex_reg_we && ex_rd==s) -> 01.
  - Else MEM match -> 10.
  - Else wb_valid && wb_rd==s -> 11.
  - Else 00.
  - Unused source or s==0 -> 00.
- RAW stall: any used source s!=0 whose busy bit is 1, unless wb_valid && wb_rd==s this cycle (same-cycle bypass via 11).
- WAW stall: id_reg_we && id_rd!=0 && busy[id_rd], unless wb_valid && wb_rd==id_rd.
- Capacity stall: id_long && busy_cnt==MAX_OUT && !wb_valid.
- stall = id_valid && (RAW | WAW | capacity) && FSM==IDLE. stall is never asserted while flushing.
- Issue fires when id_valid && !stall && FSM==IDLE && !redirect.
- If a long op issues with rd!=0, busy[rd] is set at the next edge.
- A long op with rd==0 still counts in busy_cnt but sets no bit.
- wb_valid clears busy[wb_rd] and decrements busy_cnt at the next edge.
- Same cycle issue and wb to the same register: the bit ends at 1 and the count is unchanged.
- busy_cnt never over- or under-flows. wb_valid with busy_cnt==0 is ignored, and an SVA flags it.
- FSM, IDLE:
  - redirect -> FLUSH with down-counter = FLUSH_CYC-1.
  - flush is asserted combinationally in the redirect cycle.
- FSM, FLUSH:
  - flush=1 every cycle; counter decrements; at 0 -> IDLE.
  - A redirect while in FLUSH reloads the counter to FLUSH_CYC-1.
- Total flush duration: exactly FLUSH_CYC cycles from the last redirect.
- During flush, no issue occurs, but wb_valid still retires busy bits and the count. Long ops already in flight are never cancelled.
- Redirect takes priority over stall in the same cycle: stall=0, flush=1.

Test Plan:
- Reset mid-operation: busy_cnt=3, FSM=FLUSH, assert rst -> all outputs at reset values asynchronously, before the next edge. Release rst -> first issue proceeds with no stall.
- Forward priority: ex_rd=mem_rd=5, both we=1, wb_rd=5, id_rs1=5 -> fwd_a=01. Clear ex_reg_we -> 10. Clear mem_reg_we -> 11 only when wb_valid=1. id_rs1=0 -> 00.
- Long RAW: issue long op rd=7; next instruction reads x7 -> stall=1, if_we=0 until the wb_valid/wb_rd=7 cycle. In that cycle stall=0 and fwd_a=11; busy[7]=0 afterwards.
- Capacity: issue 4 long ops (MAX_OUT=4) with rd=1..4; fifth long op stalls. Same cycle as wb_valid -> issues, busy_cnt stays 4.
- Flush: redirect pulse at cycle t (FLUSH_CYC=2) -> flush=1 at t and t+1, 0 at t+2. Second redirect at t+1 -> flush through t+2. Concurrent RAW hazard -> stall=0 throughout.
- Same-register collision: wb_valid wb_rd=9 while a long op with rd=9 issues -> busy[9]=1, busy_cnt unchanged, WAW check passes that cycle.
